fifo_word_packer: RTL and testbench

- Read-side consumer of the asynchronous byte FIFO, running entirely in the FIFO read clock domain.
- Pops 8-bit bytes from the FIFO read port and assembles them into 16-bit words in PDP-11 little-endian order: first byte is the low byte.
- Presents the words on a valid/ready interface to the Qbus DMA word engine for a programmed word count, then pulses Done.

---
 rtl/qsic_fifo_pkg.sv | 17 +
 rtl/fifo_word_packer.sv | 131 +++++++++++++
 tb/tb_fifo_word_packer.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/qsic_fifo_pkg.sv
// qsic_fifo_pkg
// Shared definitions for the read side of the asynchronous byte FIFO:
//   - BYTE_WIDTH_DEF : default width of one FIFO data word
//   - packer_state_t : word packer FSM states
package qsic_fifo_pkg;

    localparam int BYTE_WIDTH_DEF = 8;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        FETCH_LO = 3'd1,
        FETCH_HI = 3'd2,
        CAPTURE  = 3'd3,
        OUTPUT   = 3'd4
    } packer_state_t;

endpackage

// File: rtl/fifo_word_packer.sv
// fifo_word_packer
// Read-clock-domain consumer of the async byte FIFO. Pops pairs of bytes,
// packs them little-endian (first byte = low byte) into words and hands them
// to the Qbus DMA word engine over valid/ready for a programmed word count,
// then pulses Done_out.
//
// Ports:
//   RClk            FIFO read clock, all state on rising edge
//   PresetFull      asynchronous active-high reset
//   Fifo_Data_in    FIFO read data, valid the cycle after an accepted read
//   Fifo_Empty_in   FIFO empty flag
//   Fifo_ReadEn_out FIFO read enable, never high while Fifo_Empty_in is high
//   Start_in        one-cycle start pulse, ignored while busy
//   WordCount_in    words to transfer, sampled with Start_in
//   Word_out        assembled word {high byte, low byte}
//   WordValid_out   Word_out valid
//   WordReady_in    consumer accepts Word_out
//   Busy_out        transfer in progress
//   Done_out        one-cycle pulse when the transfer completes
module fifo_word_packer
    import qsic_fifo_pkg::*;
#(
    parameter int BYTE_WIDTH  = BYTE_WIDTH_DEF,
    parameter int COUNT_WIDTH = 16
) (
    input  logic                    RClk,
    input  logic                    PresetFull,
    input  logic [BYTE_WIDTH-1:0]   Fifo_Data_in,
    input  logic                    Fifo_Empty_in,
    output logic                    Fifo_ReadEn_out,
    input  logic                    Start_in,
    input  logic [COUNT_WIDTH-1:0]  WordCount_in,
    output logic [2*BYTE_WIDTH-1:0] Word_out,
    output logic                    WordValid_out,
    input  logic                    WordReady_in,
    output logic                    Busy_out,
    output logic                    Done_out
);

    packer_state_t           state_q;
    logic [COUNT_WIDTH-1:0]  remaining_q;
    logic                    rd_q;        // a read was accepted last cycle
    logic                    byte_sel_q;  // 0: last read was the low byte
    logic [BYTE_WIDTH-1:0]   lo_q;
    logic [2*BYTE_WIDTH-1:0] word_q;
    logic                    valid_q;
    logic                    busy_q;
    logic                    done_q;
    logic                    rd_req;

    // Read request only in the fetch states; gating with Empty here keeps the
    // enable itself equal to "accepted read".
    assign rd_req          = (state_q == FETCH_LO) || (state_q == FETCH_HI);
    assign Fifo_ReadEn_out = rd_req & ~Fifo_Empty_in;

    assign Word_out      = word_q;
    assign WordValid_out = valid_q;
    assign Busy_out      = busy_q;
    assign Done_out      = done_q;

    always_ff @(posedge RClk or posedge PresetFull) begin
        if (PresetFull) begin
            state_q     <= IDLE;
            remaining_q <= '0;
            rd_q        <= 1'b0;
            byte_sel_q  <= 1'b0;
            lo_q        <= '0;
            word_q      <= '0;
            valid_q     <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            rd_q   <= Fifo_ReadEn_out;

            // Low byte lands one cycle after its read, i.e. in the first
            // FETCH_HI cycle; later stall cycles in FETCH_HI have rd_q low.
            if (rd_q && !byte_sel_q)
                lo_q <= Fifo_Data_in;

            case (state_q)
                IDLE: begin
                    if (Start_in) begin
                        remaining_q <= WordCount_in;
                        if (WordCount_in == '0) begin
                            done_q <= 1'b1;
                        end else begin
                            busy_q  <= 1'b1;
                            state_q <= FETCH_LO;
                        end
                    end
                end
                FETCH_LO: begin
                    if (Fifo_ReadEn_out) begin
                        byte_sel_q <= 1'b0;
                        state_q    <= FETCH_HI;
                    end
                end
                FETCH_HI: begin
                    if (Fifo_ReadEn_out) begin
                        byte_sel_q <= 1'b1;
                        state_q    <= CAPTURE;
                    end
                end
                CAPTURE: begin
                    // Only reachable the cycle after the high-byte read, so
                    // the data port holds the high byte now.
                    word_q  <= {Fifo_Data_in, lo_q};
                    valid_q <= 1'b1;
                    state_q <= OUTPUT;
                end
                OUTPUT: begin
                    if (WordReady_in) begin
                        valid_q <= 1'b0;
                        if (remaining_q != '0)
                            remaining_q <= remaining_q - COUNT_WIDTH'(1);
                        if (remaining_q <= COUNT_WIDTH'(1)) begin
                            done_q  <= 1'b1;
                            busy_q  <= 1'b0;
                            state_q <= IDLE;
                        end else begin
                            state_q <= FETCH_LO;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_word_packer.sv
module tb_fifo_word_packer;

    logic        RClk = 1'b0;
    logic        PresetFull = 1'b1;
    logic [7:0]  Fifo_Data_in = 8'h00;
    logic        Fifo_Empty_in = 1'b1;
    logic        Fifo_ReadEn_out;
    logic        Start_in = 1'b0;
    logic [15:0] WordCount_in = 16'h0;
    logic [15:0] Word_out;
    logic        WordValid_out;
    logic        WordReady_in = 1'b1;
    logic        Busy_out;
    logic        Done_out;

    fifo_word_packer dut (
        .RClk            (RClk),
        .PresetFull      (PresetFull),
        .Fifo_Data_in    (Fifo_Data_in),
        .Fifo_Empty_in   (Fifo_Empty_in),
        .Fifo_ReadEn_out (Fifo_ReadEn_out),
        .Start_in        (Start_in),
        .WordCount_in    (WordCount_in),
        .Word_out        (Word_out),
        .WordValid_out   (WordValid_out),
        .WordReady_in    (WordReady_in),
        .Busy_out        (Busy_out),
        .Done_out        (Done_out)
    );

    always #5 RClk = ~RClk;

    int          total = 0;
    int          bad   = 0;
    int          reads = 0;
    int          words = 0;
    int          dones = 0;
    int          viol  = 0;
    bit          flush = 1'b0;
    logic [15:0] exp_q[$];
    logic [7:0]  fq[$];
    logic [7:0]  pend[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, req);
        end
    endtask

    // Byte FIFO model: data is registered one cycle after an accepted read,
    // new bytes become visible the edge after they are pushed.
    initial forever begin
        @(posedge RClk);
        if (Fifo_ReadEn_out && !Fifo_Empty_in && fq.size() > 0)
            Fifo_Data_in <= fq.pop_front();
        if (flush)
            fq.delete();
        while (pend.size() > 0)
            fq.push_back(pend.pop_front());
        Fifo_Empty_in <= (fq.size() == 0);
    end

    // Monitor: scoreboard pops on each handshake, plus protocol watch.
    initial begin
        logic        stall = 1'b0;
        logic        prev_done = 1'b0;
        logic [15:0] held = 16'h0;
        forever begin
            @(negedge RClk);
            if (Fifo_ReadEn_out && Fifo_Empty_in) viol++;
            if (Fifo_ReadEn_out && WordValid_out) viol++;
            if (Fifo_ReadEn_out && !Fifo_Empty_in) reads++;
            if (Done_out) begin
                dones++;
                if (prev_done) viol++;
            end
            prev_done = Done_out;
            if (stall) begin
                chk("stall_valid", {31'd0, WordValid_out}, 32'd1);
                chk("stall_word", {16'd0, Word_out}, {16'd0, held});
            end
            if (WordValid_out && WordReady_in) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_word: got %0h want none", Word_out);
                end else begin
                    chk("word", {16'd0, Word_out}, {16'd0, exp_q.pop_front()});
                end
                words++;
            end
            stall = WordValid_out && !WordReady_in && !PresetFull;
            held  = Word_out;
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge RClk);
            #1;
        end
    endtask

    task automatic start(input int n);
        Start_in     = 1'b1;
        WordCount_in = n[15:0];
        tick();
        Start_in     = 1'b0;
    endtask

    task automatic wait_done(input string nm, input int budget);
        int d0 = dones;
        bit seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            tick();
            if (dones != d0) seen = 1'b1;
        end
        if (!seen) begin
            total++;
            bad++;
            $display("FAIL %s_timeout: got no Done want Done", nm);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int r0, d0, w0;
        bit seen;

        // reset state
        tick(2);
        chk("rst_readen", {31'd0, Fifo_ReadEn_out}, 32'd0);
        chk("rst_valid", {31'd0, WordValid_out}, 32'd0);
        chk("rst_busy", {31'd0, Busy_out}, 32'd0);
        chk("rst_done", {31'd0, Done_out}, 32'd0);
        chk("rst_word", {16'd0, Word_out}, 32'd0);
        PresetFull = 1'b0;
        tick();

        // two words from preloaded bytes, latency check
        pend.push_back(8'h34); pend.push_back(8'h12);
        pend.push_back(8'h78); pend.push_back(8'h56);
        tick();
        r0 = reads; d0 = dones; w0 = words;
        exp_q.push_back(16'h1234); exp_q.push_back(16'h5678);
        start(2);
        chk("t1_busy", {31'd0, Busy_out}, 32'd1);
        tick(2);
        chk("t1_valid_early", {31'd0, WordValid_out}, 32'd0);
        tick();
        chk("t1_valid_c4", {31'd0, WordValid_out}, 32'd1);
        chk("t1_word0", {16'd0, Word_out}, 32'h1234);
        wait_done("t1", 20);
        chk("t1_reads", reads - r0, 4);
        chk("t1_dones", dones - d0, 1);
        chk("t1_words", words - w0, 2);
        chk("t1_busy_end", {31'd0, Busy_out}, 32'd0);

        // second byte arrives late
        pend.push_back(8'h34);
        tick();
        w0 = words;
        exp_q.push_back(16'h1234);
        start(1);
        tick(9);
        chk("t2_no_word_yet", {31'd0, WordValid_out}, 32'd0);
        pend.push_back(8'h12);
        wait_done("t2", 20);
        chk("t2_words", words - w0, 1);
        chk("t2_viol", viol, 0);

        // consumer back-pressure for 5 cycles
        WordReady_in = 1'b0;
        pend.push_back(8'hA1); pend.push_back(8'hB2);
        pend.push_back(8'hC3); pend.push_back(8'hD4);
        tick();
        exp_q.push_back(16'hB2A1); exp_q.push_back(16'hD4C3);
        start(2);
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            if (WordValid_out) seen = 1'b1;
            else tick();
        end
        chk("t3_valid_seen", {31'd0, seen}, 32'd1);
        r0 = reads;
        tick(5);
        chk("t3_stall_reads", reads - r0, 0);
        chk("t3_held_word", {16'd0, Word_out}, 32'hB2A1);
        WordReady_in = 1'b1;
        wait_done("t3", 20);
        chk("t3_sb_empty", exp_q.size(), 0);
        chk("t3_viol", viol, 0);

        // zero word count
        r0 = reads; d0 = dones; w0 = words;
        start(0);
        chk("t4_done", {31'd0, Done_out}, 32'd1);
        tick();
        chk("t4_done_pulse", {31'd0, Done_out}, 32'd0);
        tick(3);
        chk("t4_reads", reads - r0, 0);
        chk("t4_words", words - w0, 0);
        chk("t4_dones", dones - d0, 1);

        // async reset inside FETCH_HI, then a clean transfer
        pend.push_back(8'h11); pend.push_back(8'h22);
        tick();
        d0 = dones;
        start(1);
        tick();
        #2 PresetFull = 1'b1;
        #1;
        chk("t5_rst_readen", {31'd0, Fifo_ReadEn_out}, 32'd0);
        chk("t5_rst_valid", {31'd0, WordValid_out}, 32'd0);
        chk("t5_rst_busy", {31'd0, Busy_out}, 32'd0);
        chk("t5_rst_done", {31'd0, Done_out}, 32'd0);
        chk("t5_rst_word", {16'd0, Word_out}, 32'd0);
        tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        tick(2);
        PresetFull = 1'b0;
        tick();
        pend.push_back(8'hCD); pend.push_back(8'hAB);
        tick();
        exp_q.push_back(16'hABCD);
        start(1);
        wait_done("t5", 20);
        chk("t5_dones", dones - d0, 1);
        chk("t5_word_hold", {16'd0, Word_out}, 32'hABCD);

        // restart attempt during a 3-word transfer
        for (int b = 1; b <= 6; b++) pend.push_back(8'(b));
        tick();
        d0 = dones; w0 = words;
        exp_q.push_back(16'h0201); exp_q.push_back(16'h0403); exp_q.push_back(16'h0605);
        start(3);
        tick(3);
        start(5);
        wait_done("t6", 40);
        tick(12);
        chk("t6_words", words - w0, 3);
        chk("t6_dones", dones - d0, 1);
        chk("t6_busy", {31'd0, Busy_out}, 32'd0);
        chk("t6_sb_empty", exp_q.size(), 0);
        chk("final_viol", viol, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
